// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The FAULT state exists only when IFETCH_MISALIGN_EN is defined.
package ifetch_pkg;

   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned PC_STEP = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
`ifdef IFETCH_MISALIGN_EN
      ST_HOLD  = 2'd2,
      ST_FAULT = 2'd3
`else
      ST_HOLD  = 2'd2
`endif
   } ifetch_state_e;

endpackage : ifetch_pkg

// File: rtl/instr_fetch.sv
// Instruction fetch: memory request/ack on one side, valid/ready to decode on the other.
// Optional IFETCH_MISALIGN_EN adds a FAULT state and fault port for misaligned PCs.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   pc,
   output logic [ADDR_W-1:0]   new_address,
   output logic                imem_req,
   output logic [ADDR_W-1:0]   imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                instr_valid,
   output logic [INSTR_W-1:0]  instr,
   output logic [ADDR_W-1:0]   instr_pc,
   input  logic                instr_ready,
`ifdef IFETCH_MISALIGN_EN
   output logic                fault,
`endif
   input  logic                redirect,
   input  logic [ADDR_W-1:0]   redirect_addr
);

   ifetch_state_e        state_q;
   logic [INSTR_W-1:0]   instr_q;
   logic [ADDR_W-1:0]    instr_pc_q;
   logic                 misalign_c;
   logic                 fetch_done_c;

`ifdef IFETCH_MISALIGN_EN
   assign misalign_c = (pc[1:0] != 2'b00);
   assign fault      = (state_q == ST_FAULT);
`else
   assign misalign_c = 1'b0;
`endif

   // A fetch completes only on a real request that memory acknowledges.
   assign fetch_done_c = (state_q == ST_REQ) && !misalign_c && imem_ack;

   assign imem_req    = (state_q == ST_REQ) && !misalign_c;
   assign imem_addr   = {pc[ADDR_W-1:2], 2'b00};
   assign instr_valid = (state_q == ST_HOLD);
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;

   // Next-PC mux: reset beats redirect beats sequential advance.
   always_comb begin
      new_address = pc;
      if (fetch_done_c) begin
         new_address = pc + ADDR_W'(PC_STEP);
      end
      if (redirect) begin
         new_address = redirect_addr;
      end
      if (reset) begin
         new_address = RESET_VECTOR;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         instr_q    <= '0;
         instr_pc_q <= '0;
      end else if (redirect) begin
         // Redirect discards any same-cycle rdata and restarts fetch.
         state_q <= ST_REQ;
      end else begin
         case (state_q)
            ST_IDLE: state_q <= ST_REQ;
            ST_REQ: begin
               if (misalign_c) begin
`ifdef IFETCH_MISALIGN_EN
                  state_q <= ST_FAULT;
`else
                  state_q <= ST_REQ;
`endif
               end else if (imem_ack) begin
                  state_q    <= ST_HOLD;
                  instr_q    <= imem_rdata;
                  instr_pc_q <= pc;
               end
            end
            ST_HOLD: begin
               if (instr_ready) begin
                  state_q <= ST_REQ;
               end
            end
`ifdef IFETCH_MISALIGN_EN
            ST_FAULT: state_q <= ST_FAULT;
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus pushes expected fetches, a negedge monitor checks decode-side output.
// Exercises the IFETCH_MISALIGN_EN path when that macro is defined.
module tb_instr_fetch;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic [31:0] new_address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        redirect;
   logic [31:0] redirect_addr;
`ifdef IFETCH_MISALIGN_EN
   logic        fault;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];

   instr_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .pc            (pc),
      .new_address   (new_address),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_ready   (instr_ready),
`ifdef IFETCH_MISALIGN_EN
      .fault         (fault),
`endif
      .redirect      (redirect),
      .redirect_addr (redirect_addr)
   );

   always #5 clk = ~clk;

   // PC register that closes the loop around new_address.
   always @(posedge clk or posedge reset) begin
      if (reset) pc <= 32'h0000_0000;
      else       pc <= new_address;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] data, input logic [31:0] addr);
      exp_t e;
      e.instr = data;
      e.pc    = addr;
      sb.push_back(e);
   endtask

   // Monitor: every cycle decode sees valid, the payload must match the oldest expected fetch.
   always @(negedge clk) begin
      if (reset === 1'b0 && instr_valid === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got instr %h pc %h expected no valid", instr, instr_pc);
         end else begin
            chk("mon_instr", instr, sb[0].instr);
            chk("mon_instr_pc", instr_pc, sb[0].pc);
            if (instr_ready === 1'b1) void'(sb.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
      instr_ready = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
      @(negedge clk);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
      chk("rst_new_address", new_address, 32'h0);

      // IDLE lasts one cycle after release
      tick(); reset = 1'b0; imem_ack = 1'b0;
      @(negedge clk);
      chk("idle_req", 32'(imem_req), 32'd0);
      chk("idle_new_address", new_address, 32'h0);

      // Zero-wait fetch of DEADBEEF at pc 0
      tick(); imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; push(32'hDEAD_BEEF, 32'h0);
      @(negedge clk);
      chk("f0_req", 32'(imem_req), 32'd1);
      chk("f0_addr", imem_addr, 32'h0);
      chk("f0_new_address", new_address, 32'h4);

      // HOLD with ready low for 5 cycles
      for (int i = 0; i < 5; i++) begin
         tick(); imem_ack = 1'b0; imem_rdata = 32'h0;
         @(negedge clk);
         chk("hold_req", 32'(imem_req), 32'd0);
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_new_address", new_address, 32'h4);
      end
      tick(); instr_ready = 1'b1;
      @(negedge clk);

      // Back in REQ the next cycle; ack delayed 3 cycles
      for (int i = 0; i < 3; i++) begin
         tick(); instr_ready = 1'b0; imem_ack = 1'b0;
         @(negedge clk);
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, 32'h4);
         chk("wait_new_address", new_address, 32'h4);
      end
      tick(); imem_ack = 1'b1; imem_rdata = 32'hCAFE_0001; push(32'hCAFE_0001, 32'h4);
      @(negedge clk);
      chk("wait_req4", 32'(imem_req), 32'd1);
      chk("wait_done_new_address", new_address, 32'h8);
      tick(); imem_ack = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      chk("hold2_req", 32'(imem_req), 32'd0);
      chk("hold2_new_address", new_address, 32'h8);

      // Redirect during REQ with simultaneous ack drops rdata
      tick(); instr_ready = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      redirect = 1'b1; redirect_addr = 32'h100;
      @(negedge clk);
      chk("redir_new_address", new_address, 32'h100);
      tick(); redirect = 1'b0; imem_ack = 1'b0;
      @(negedge clk);
      chk("redir_req", 32'(imem_req), 32'd1);
      chk("redir_addr", imem_addr, 32'h100);
      chk("redir_no_valid", 32'(instr_valid), 32'd0);
      tick(); imem_ack = 1'b1; imem_rdata = 32'h1234_5678; push(32'h1234_5678, 32'h100);
      @(negedge clk);
      chk("f100_new_address", new_address, 32'h104);

      // Redirect in HOLD with same-cycle ready still completes the handshake
      tick(); imem_ack = 1'b0; instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
      @(negedge clk);
      chk("hold_redir_new_address", new_address, 32'hFFFF_FFFC);
      tick(); instr_ready = 1'b0; redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hA5A5_A5A5;
      push(32'hA5A5_A5A5, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_new_address", new_address, 32'h0);
      tick(); imem_ack = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      chk("wrap_hold_new_address", new_address, 32'h0);

      // Reset pulsed mid-REQ, with an ack that must be ignored
      tick(); instr_ready = 1'b0; redirect = 1'b1; redirect_addr = 32'h200;
      @(negedge clk);
      chk("r200_new_address", new_address, 32'h200);
      tick(); redirect = 1'b0;
      @(negedge clk);
      chk("r200_req", 32'(imem_req), 32'd1);
      chk("r200_addr", imem_addr, 32'h200);
      tick(); reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
      @(negedge clk);
      chk("midrst_req", 32'(imem_req), 32'd0);
      chk("midrst_new_address", new_address, 32'h0);
      chk("midrst_instr", instr, 32'h0);
      chk("midrst_instr_pc", instr_pc, 32'h0);
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      tick(); reset = 1'b0; imem_ack = 1'b0;
      @(negedge clk);
      chk("rel_req", 32'(imem_req), 32'd0);
      chk("rel_instr", instr, 32'h0);

      // Misaligned PC
      tick(); redirect = 1'b1; redirect_addr = 32'h6;
      @(negedge clk);
      chk("mis_new_address", new_address, 32'h6);
      tick(); redirect = 1'b0;
`ifdef IFETCH_MISALIGN_EN
      @(negedge clk);
      chk("mis_req", 32'(imem_req), 32'd0);
      chk("mis_hold_pc", new_address, 32'h6);
      tick();
      @(negedge clk);
      chk("fault_set", 32'(fault), 32'd1);
      chk("fault_req", 32'(imem_req), 32'd0);
      chk("fault_new_address", new_address, 32'h6);
      tick(); redirect = 1'b1; redirect_addr = 32'h8;
      @(negedge clk);
      chk("fault_redir", new_address, 32'h8);
      tick(); redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D; push(32'h0BAD_F00D, 32'h8);
      @(negedge clk);
      chk("fault_clear", 32'(fault), 32'd0);
      chk("f8_req", 32'(imem_req), 32'd1);
      chk("f8_addr", imem_addr, 32'h8);
      chk("f8_new_address", new_address, 32'hC);
`else
      imem_ack = 1'b1; imem_rdata = 32'h0BAD_F00D; push(32'h0BAD_F00D, 32'h6);
      @(negedge clk);
      chk("mis_req", 32'(imem_req), 32'd1);
      chk("mis_addr", imem_addr, 32'h4);
      chk("mis_new_address", new_address, 32'hA);
`endif
      tick(); imem_ack = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      chk("last_valid", 32'(instr_valid), 32'd1);
      tick(); instr_ready = 1'b0;
      @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_instr_fetch
